// File: rtl/lm_sm_sequencer.sv
// Register-list sequencer for LM/SM: walks the set bits of IR[7:0] in ascending order,
// issuing one (register index, memory address) pair per step with consecutive addresses.
module lm_sm_sequencer #(
    parameter int unsigned AW   = 16,
    parameter int unsigned NREG = 8
) (
    input  logic                    clk,
    input  logic                    proc_rst,
    input  logic                    start,
    input  logic [NREG-1:0]         reg_list,
    input  logic [AW-1:0]           base_addr,
    input  logic                    step,
    output logic                    busy,
    output logic                    valid,
    output logic [$clog2(NREG)-1:0] reg_idx,
    output logic [AW-1:0]           mem_addr,
    output logic                    last,
    output logic                    done,
    output logic [3:0]              count
);

    localparam int unsigned IW = $clog2(NREG);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StActive = 2'd1;
    localparam logic [1:0] StDone   = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [NREG-1:0] mask_q, mask_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [3:0]      count_q, count_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [AW-1:0]   maddr_q, maddr_d;

    logic [NREG-1:0] mask_nxt;
    logic [AW-1:0]   addr_inc;

    function automatic logic [IW-1:0] lowest_idx(input logic [NREG-1:0] m);
        lowest_idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (m[i]) lowest_idx = IW'(i);
        end
    endfunction

    // Clearing the lowest set bit: m & (m - 1).
    assign mask_nxt = mask_q & (mask_q - NREG'(1));
    assign addr_inc = addr_q + AW'(1);

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        addr_d  = addr_q;
        count_d = count_q;
        idx_d   = idx_q;
        maddr_d = maddr_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    mask_d  = reg_list;
                    addr_d  = base_addr;
                    count_d = 4'd0;
                    if (reg_list == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StActive;
                        idx_d   = lowest_idx(reg_list);
                        maddr_d = base_addr;
                    end
                end
            end
            StActive: begin
                if (step) begin
                    mask_d  = mask_nxt;
                    addr_d  = addr_inc;
                    count_d = count_q + 4'd1;
                    // Presented pair only advances while transfers remain, so it holds afterwards.
                    if (mask_nxt == '0) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = lowest_idx(mask_nxt);
                        maddr_d = addr_inc;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (proc_rst) begin
            state_q <= StIdle;
            mask_q  <= '0;
            addr_q  <= '0;
            count_q <= '0;
            idx_q   <= '0;
            maddr_q <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            maddr_q <= maddr_d;
        end
    end

    assign busy     = (state_q == StActive) || (state_q == StDone);
    assign valid    = (state_q == StActive);
    assign last     = (state_q == StActive) && (mask_q != '0) && (mask_nxt == '0);
    assign done     = (state_q == StDone);
    assign reg_idx  = idx_q;
    assign mem_addr = maddr_q;
    assign count    = count_q;

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Directed bench for lm_sm_sequencer: sparse, empty, wrapping, stalled, reset and back-to-back lists.
module tb_lm_sm_sequencer;

    logic        clk = 1'b0;
    logic        proc_rst;
    logic        start;
    logic [7:0]  reg_list;
    logic [15:0] base_addr;
    logic        step;
    logic        busy, valid, last, done;
    logic [2:0]  reg_idx;
    logic [15:0] mem_addr;
    logic [3:0]  count;

    int vectors = 0;
    int miscompares = 0;

    lm_sm_sequencer #(.AW(16), .NREG(8)) dut (
        .clk      (clk),
        .proc_rst (proc_rst),
        .start    (start),
        .reg_list (reg_list),
        .base_addr(base_addr),
        .step     (step),
        .busy     (busy),
        .valid    (valid),
        .reg_idx  (reg_idx),
        .mem_addr (mem_addr),
        .last     (last),
        .done     (done),
        .count    (count)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are then sampled 1ns later, inputs driven there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        proc_rst = 1'b1; start = 1'b0; step = 1'b0; reg_list = '0; base_addr = '0;
        tick(); tick();
        proc_rst = 1'b0;
        vectors++;
        if ({busy, valid, last, done, reg_idx, mem_addr, count} !== 27'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got busy=%b valid=%b last=%b done=%b idx=%0d addr=%h cnt=%0d want all 0",
                     busy, valid, last, done, reg_idx, mem_addr, count);
        end
    endtask

    task automatic test_sparse();
        logic [2:0] ei [4] = '{3'd0, 3'd2, 3'd5, 3'd7};
        reg_list = 8'hA5; base_addr = 16'h0040; start = 1'b1;
        tick();
        start = 1'b0; step = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if ({valid, reg_idx, mem_addr, last, done, count} !==
                {1'b1, ei[i], 16'h0040 + 16'(i), (i == 3), 1'b0, 4'(i)}) begin
                miscompares++;
                $display("FAIL sparse_pair%0d got v=%b idx=%0d addr=%h last=%b done=%b cnt=%0d want idx=%0d addr=%h",
                         i, valid, reg_idx, mem_addr, last, done, count, ei[i], 16'h0040 + 16'(i));
            end
            tick();
        end
        step = 1'b0;
        vectors++;
        if ({done, valid, busy, count} !== {1'b1, 1'b0, 1'b1, 4'd4}) begin
            miscompares++;
            $display("FAIL sparse_done got done=%b valid=%b busy=%b cnt=%0d want 1 0 1 4",
                     done, valid, busy, count);
        end
        tick();
        vectors++;
        if ({done, busy, reg_idx, mem_addr, count} !== {1'b0, 1'b0, 3'd7, 16'h0043, 4'd4}) begin
            miscompares++;
            $display("FAIL sparse_idle got done=%b busy=%b idx=%0d addr=%h cnt=%0d want 0 0 7 0043 4",
                     done, busy, reg_idx, mem_addr, count);
        end
    endtask

    task automatic test_empty();
        reg_list = 8'h00; base_addr = 16'h1234; start = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if ({valid, done, busy, count} !== {1'b0, 1'b1, 1'b1, 4'd0}) begin
            miscompares++;
            $display("FAIL empty_done got valid=%b done=%b busy=%b cnt=%0d want 0 1 1 0",
                     valid, done, busy, count);
        end
        tick();
        vectors++;
        if ({valid, done, busy, reg_idx, mem_addr} !== {1'b0, 1'b0, 1'b0, 3'd7, 16'h0043}) begin
            miscompares++;
            $display("FAIL empty_idle got valid=%b done=%b busy=%b idx=%0d addr=%h want 0 0 0 7 0043",
                     valid, done, busy, reg_idx, mem_addr);
        end
    endtask

    task automatic test_wrap();
        reg_list = 8'hFF; base_addr = 16'hFFFE; start = 1'b1;
        tick();
        start = 1'b0; step = 1'b1;
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if ({valid, reg_idx, mem_addr, last} !== {1'b1, 3'(i), 16'hFFFE + 16'(i), (i == 7)}) begin
                miscompares++;
                $display("FAIL wrap_pair%0d got v=%b idx=%0d addr=%h last=%b want idx=%0d addr=%h",
                         i, valid, reg_idx, mem_addr, last, i, 16'hFFFE + 16'(i));
            end
            tick();
        end
        step = 1'b0;
        vectors++;
        if ({done, count} !== {1'b1, 4'd8}) begin
            miscompares++;
            $display("FAIL wrap_done got done=%b cnt=%0d want 1 8", done, count);
        end
        tick();
    endtask

    task automatic test_stall_ignore();
        reg_list = 8'h81; base_addr = 16'h0100; start = 1'b1;
        tick();
        start = 1'b0;
        for (int g = 0; g < 3; g++) begin
            vectors++;
            if ({valid, reg_idx, mem_addr, last, count} !== {1'b1, 3'd0, 16'h0100, 1'b0, 4'd0}) begin
                miscompares++;
                $display("FAIL stall_hold%0d got v=%b idx=%0d addr=%h last=%b cnt=%0d want 1 0 0100 0 0",
                         g, valid, reg_idx, mem_addr, last, count);
            end
            if (g == 1) begin
                reg_list = 8'h3C; base_addr = 16'h0200; start = 1'b1;
            end
            tick();
            start = 1'b0;
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        for (int g = 0; g < 3; g++) begin
            vectors++;
            if ({valid, reg_idx, mem_addr, last, count} !== {1'b1, 3'd7, 16'h0101, 1'b1, 4'd1}) begin
                miscompares++;
                $display("FAIL stall_second%0d got v=%b idx=%0d addr=%h last=%b cnt=%0d want 1 7 0101 1 1",
                         g, valid, reg_idx, mem_addr, last, count);
            end
            tick();
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        vectors++;
        if ({done, count} !== {1'b1, 4'd2}) begin
            miscompares++;
            $display("FAIL stall_done got done=%b cnt=%0d want 1 2", done, count);
        end
        tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        vectors++;
        if ({busy, valid, done, reg_idx, mem_addr, count} !==
            {1'b0, 1'b0, 1'b0, 3'd7, 16'h0101, 4'd2}) begin
            miscompares++;
            $display("FAIL idle_step got busy=%b v=%b done=%b idx=%0d addr=%h cnt=%0d want 0 0 0 7 0101 2",
                     busy, valid, done, reg_idx, mem_addr, count);
        end
    endtask

    task automatic test_reset_mid();
        reg_list = 8'h0F; base_addr = 16'h0010; start = 1'b1;
        tick();
        start = 1'b0; step = 1'b1;
        tick(); tick();
        step = 1'b0; proc_rst = 1'b1;
        tick();
        proc_rst = 1'b0;
        vectors++;
        if ({busy, valid, done, last, reg_idx, mem_addr, count} !== 27'd0) begin
            miscompares++;
            $display("FAIL reset_mid got busy=%b v=%b done=%b last=%b idx=%0d addr=%h cnt=%0d want all 0",
                     busy, valid, done, last, reg_idx, mem_addr, count);
        end
        tick();
        vectors++;
        if ({busy, done} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_nodone got busy=%b done=%b want 0 0", busy, done);
        end
        reg_list = 8'h02; base_addr = 16'h0030; start = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if ({valid, reg_idx, mem_addr, last} !== {1'b1, 3'd1, 16'h0030, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_restart got v=%b idx=%0d addr=%h last=%b want 1 1 0030 1",
                     valid, reg_idx, mem_addr, last);
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        vectors++;
        if ({done, count} !== {1'b1, 4'd1}) begin
            miscompares++;
            $display("FAIL reset_restart_done got done=%b cnt=%0d want 1 1", done, count);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        reg_list = 8'h01; base_addr = 16'h0050; start = 1'b1;
        tick();
        start = 1'b0; step = 1'b1;
        tick();
        step = 1'b0;
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_done got done=%b want 1", done);
        end
        reg_list = 8'h04; base_addr = 16'h0060; start = 1'b1;
        tick();
        vectors++;
        if ({busy, valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL b2b_dropped got busy=%b v=%b want 0 0", busy, valid);
        end
        tick();
        start = 1'b0;
        vectors++;
        if ({valid, reg_idx, mem_addr, count} !== {1'b1, 3'd2, 16'h0060, 4'd0}) begin
            miscompares++;
            $display("FAIL b2b_accepted got v=%b idx=%0d addr=%h cnt=%0d want 1 2 0060 0",
                     valid, reg_idx, mem_addr, count);
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        vectors++;
        if ({done, count} !== {1'b1, 4'd1}) begin
            miscompares++;
            $display("FAIL b2b_finish got done=%b cnt=%0d want 1 1", done, count);
        end
        tick();
    endtask

    initial begin
        #1;
        test_reset();
        test_sparse();
        test_empty();
        test_wrap();
        test_stall_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
